// File: rtl/signed_bcd_display_if.sv
// Bus between a debug tap and the signed BCD display driver: load request,
// conversion status and the multiplexed segment/digit outputs.
interface signed_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) ();
    logic [WIDTH-1:0]  BinaryInput;
    logic              Load;
    logic              Busy;
    logic              Done;
    logic              SignOut;
    logic              Overflow;
    logic [6:0]        Segments;
    logic [DIGITS-1:0] DigitSelect;

    modport master (
        output BinaryInput, Load,
        input  Busy, Done, SignOut, Overflow, Segments, DigitSelect
    );

    modport slave (
        input  BinaryInput, Load,
        output Busy, Done, SignOut, Overflow, Segments, DigitSelect
    );
endinterface

// File: rtl/signed_bcd_display.sv
// Signed binary to time-multiplexed 7-segment display driver (shift-add-3 BCD).
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module signed_bcd_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    signed_bcd_display_if.slave  bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [SCAN_W-1:0] LAST_SCAN  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [6:0]        SEG_DASH   = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0]        SEG_RESET  = 7'b0000000;
`else
    localparam logic [6:0]        SEG_RESET  = 7'b0111111;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_mag;
    logic [BCD_W-1:0]  r_bcd;
    logic              r_sign;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [BCD_W-1:0]  r_disp_bcd;
    logic              r_disp_sign;
    logic              r_disp_ovf;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [IDX_W-1:0]  r_dig_idx;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_dsel;

    logic [WIDTH-1:0]  w_mag_in;
    logic [BCD_W-1:0]  w_bcd_adj;
    logic [IDX_W-1:0]  w_idx_next;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // Unsigned negation keeps the most negative input as 2^(WIDTH-1).
    assign w_mag_in = bus.BinaryInput[WIDTH-1] ? (~bus.BinaryInput) + WIDTH'(1)
                                               : bus.BinaryInput;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: the committed display registers are reset too, so an aborted conversion shows zero.
        if (reset) begin
            r_state     <= IDLE;
            r_mag       <= '0;
            r_bcd       <= '0;
            r_sign      <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_disp_bcd  <= '0;
            r_disp_sign <= 1'b0;
            r_disp_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Load) begin
                        r_sign  <= bus.BinaryInput[WIDTH-1];
                        r_mag   <= w_mag_in;
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_busy <= 1'b1;
                    r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_mag[WIDTH-1]};
                    r_ovf  <= r_ovf | w_bcd_adj[BCD_W-1];
                    r_mag  <= {r_mag[WIDTH-2:0], 1'b0};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_SHIFT) r_state <= COMMIT;
                end
                COMMIT: begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_disp_bcd  <= r_bcd;
                    r_disp_sign <= r_sign;
                    r_disp_ovf  <= r_ovf;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Segments are decoded for the index being selected next, so both register together.
    always_comb begin
        w_idx_next = r_dig_idx;
        if (r_scan_cnt == LAST_SCAN) begin
            w_idx_next = (r_dig_idx == LAST_IDX) ? '0 : r_dig_idx + IDX_W'(1);
        end
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_next == IDX_W'(i)) w_digit = r_disp_bcd[4*i +: 4];
        end
        w_seg_next = r_disp_ovf ? SEG_DASH : seg_decode(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic w_upper_zero;
            w_upper_zero = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (i >= int'(w_idx_next) && r_disp_bcd[4*i +: 4] != 4'd0) w_upper_zero = 1'b0;
            end
            if (!r_disp_ovf && w_idx_next != '0 && w_upper_zero) w_seg_next = 7'b0000000;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= '0;
            r_dsel     <= DIGITS'(1);
            r_seg      <= SEG_RESET;
        end else begin
            r_scan_cnt <= (r_scan_cnt == LAST_SCAN) ? '0 : r_scan_cnt + SCAN_W'(1);
            r_dig_idx  <= w_idx_next;
            r_dsel     <= DIGITS'(1) << w_idx_next;
            r_seg      <= w_seg_next;
        end
    end

    assign bus.Busy        = r_busy;
    assign bus.Done        = r_done;
    assign bus.SignOut     = r_disp_sign;
    assign bus.Overflow    = r_disp_ovf;
    assign bus.Segments    = r_seg;
    assign bus.DigitSelect = r_dsel;
endmodule

// File: tb/tb_signed_bcd_display.sv
// Self-checking bench: a 3-digit instance (SCAN_DIV=4) and a 2-digit instance
// (SCAN_DIV=2), checked against an arithmetic decimal model.
module tb_signed_bcd_display;
    localparam logic [6:0] PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                        7'b1111111, 7'b1101111};

    typedef struct {
        bit          on_b;
        logic [7:0]  value;
        bit          exp_sign;
        bit          exp_ovf;
        int          d2, d1, d0;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ld = 1'b0;
    logic [7:0] bin = 8'h00;
    bit         sel_b = 1'b0;
    int         total = 0;
    int         bad = 0;

    signed_bcd_display_if #(.WIDTH(8), .DIGITS(3)) if_a ();
    signed_bcd_display_if #(.WIDTH(8), .DIGITS(2)) if_b ();

    signed_bcd_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a));
    signed_bcd_display #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(2)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b));

    always #5 clk = ~clk;

    assign if_a.Load        = ld & ~sel_b;
    assign if_b.Load        = ld & sel_b;
    assign if_a.BinaryInput = bin;
    assign if_b.BinaryInput = bin;

    logic       busy_m, done_m, sign_m, ovf_m;
    logic [6:0] seg_m;
    logic [2:0] dsel_m;
    assign busy_m = sel_b ? if_b.Busy : if_a.Busy;
    assign done_m = sel_b ? if_b.Done : if_a.Done;
    assign sign_m = sel_b ? if_b.SignOut : if_a.SignOut;
    assign ovf_m  = sel_b ? if_b.Overflow : if_a.Overflow;
    assign seg_m  = sel_b ? if_b.Segments : if_a.Segments;
    assign dsel_m = sel_b ? {1'b0, if_b.DigitSelect} : if_a.DigitSelect;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected pattern for digit i given the decimal digits of the displayed value.
    function automatic logic [6:0] seg_for(input int d2, input int d1, input int d0,
                                           input bit ovf, input int i);
        int d[3];
        d = '{d0, d1, d2};
        if (ovf) return 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 2 && d2 == 0) return 7'b0000000;
        if (i == 1 && d2 == 0 && d1 == 0) return 7'b0000000;
`endif
        return PAT[d[i]];
    endfunction

    // Watch one full scan period and compare every digit seen with the model.
    task automatic check_display(input int d2, input int d1, input int d0,
                                 input bit ovf, input string tag);
        int nd, sd, idx;
        logic [2:0] seen;
        nd = sel_b ? 2 : 3;
        sd = sel_b ? 2 : 4;
        seen = '0;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done_m, 1'b0);
        for (int c = 0; c < nd * sd; c++) begin
            @(negedge clk);
            idx = -1;
            for (int i = 0; i < nd; i++) if (dsel_m == (3'b001 << i)) idx = i;
            check({tag, "_dsel_onehot"}, idx >= 0, 1'b1);
            if (idx >= 0) begin
                seen[idx] = 1'b1;
                check({tag, "_seg"}, seg_m, seg_for(d2, d1, d0, ovf, idx));
            end
        end
        check({tag, "_all_digits_scanned"}, seen, sel_b ? 3'b011 : 3'b111);
    endtask

    task automatic run_and_check(input logic [7:0] v, input bit esign, input bit eovf,
                                 input int d2, input int d1, input int d0, input string tag);
        int lat, bn;
        bit s_o, o_o;
        @(negedge clk);
        bin = v;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        lat = -1;
        bn = 0;
        s_o = 1'b0;
        o_o = 1'b0;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            @(negedge clk);
            if (busy_m) bn++;
            if (done_m) begin
                lat = k;
                s_o = sign_m;
                o_o = ovf_m;
                check({tag, "_busy_low_at_done"}, busy_m, 1'b0);
            end
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_cycles"}, bn, 8);
        check({tag, "_sign"}, s_o, esign);
        check({tag, "_overflow"}, o_o, eovf);
        check_display(d2, d1, d0, eovf, tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   dones, lat, s, mag, lim;
        logic [7:0] v;

        vecs[0] = '{1'b0, 8'h7B, 1'b0, 1'b0, 1, 2, 3};
        vecs[1] = '{1'b0, 8'h80, 1'b1, 1'b0, 1, 2, 8};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, 1'b0, 0, 0, 1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0};
        vecs[4] = '{1'b0, 8'h81, 1'b1, 1'b0, 1, 2, 7};
        vecs[5] = '{1'b1, 8'h64, 1'b0, 1'b1, 0, 0, 0};
        vecs[6] = '{1'b1, 8'h63, 1'b0, 1'b0, 0, 9, 9};
        vecs[7] = '{1'b1, 8'h9C, 1'b1, 1'b1, 0, 0, 0};
        vecs[8] = '{1'b1, 8'h9D, 1'b1, 1'b0, 0, 9, 9};

        // Reset state and scan sequence of the 3-digit instance.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", if_a.Busy, 1'b0);
        check("reset_done", if_a.Done, 1'b0);
        check("reset_sign", if_a.SignOut, 1'b0);
        check("reset_ovf", if_a.Overflow, 1'b0);
        check("reset_dsel", if_a.DigitSelect, 3'b001);
`ifdef LEADING_ZERO_BLANK_EN
        check("reset_seg", if_a.Segments, 7'b0000000);
`else
        check("reset_seg", if_a.Segments, 7'b0111111);
`endif
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check("scan_dsel", if_a.DigitSelect, 3'b001 << ((k / 4) % 3));
            check("scan_seg", if_a.Segments, seg_for(0, 0, 0, 1'b0, (k / 4) % 3));
        end

        // Directed vectors.
        foreach (vecs[n]) begin
            sel_b = vecs[n].on_b;
            run_and_check(vecs[n].value, vecs[n].exp_sign, vecs[n].exp_ovf,
                          vecs[n].d2, vecs[n].d1, vecs[n].d0, "vec");
        end

        // Randomized values against the decimal model.
        for (int n = 0; n < 30; n++) begin
            sel_b = (n % 3 == 2);
            v = 8'($urandom_range(0, 255));
            s = int'($signed(v));
            mag = (s < 0) ? -s : s;
            lim = sel_b ? 99 : 999;
            run_and_check(v, s < 0, mag > lim, (mag / 100) % 10, (mag / 10) % 10,
                          mag % 10, "rand");
        end

        // Load while busy is ignored; exactly one Done.
        sel_b = 1'b0;
        @(negedge clk);
        bin = 8'h05;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        dones = 0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done_m) begin
                dones++;
                if (lat < 0) lat = k;
            end
            if (k == 2) begin
                check("ignored_load_busy", busy_m, 1'b1);
                bin = 8'h09;
                ld = 1'b1;
            end
            if (k == 3) ld = 1'b0;
        end
        check("ignored_load_dones", dones, 1);
        check("ignored_load_latency", lat, 9);
        check("ignored_load_sign", sign_m, 1'b0);
        check_display(0, 0, 5, 1'b0, "ignored_load");

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin = 8'h7B;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy_m, 1'b0);
        check("abort_done", done_m, 1'b0);
        check("abort_sign", sign_m, 1'b0);
        check("abort_ovf", ovf_m, 1'b0);
        check("abort_dsel", dsel_m, 3'b001);
`ifdef LEADING_ZERO_BLANK_EN
        check("abort_seg", seg_m, 7'b0000000);
`else
        check("abort_seg", seg_m, 7'b0111111);
`endif
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done_m) dones++;
        end
        check("abort_no_done", dones, 0);
        check_display(0, 0, 0, 1'b0, "abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/signed_bcd_display.md
# signed_bcd_display

Parametrised signed binary to multi-digit 7-segment display driver. It accepts a two's-complement value on a load strobe, converts its magnitude to BCD with an iterative shift-add-3 engine, and holds the result. It time-multiplexes the digits onto one shared segment bus with a one-hot digit select. It sits between datapath debug taps (register/ALU outputs) and the board's display pins, and replaces the fixed 8-bit, two-digit combinational display path.

## Interface
- WIDTH, 8, bit width of the signed input (≥2)
- DIGITS, 3, number of decimal digits driven (≥1); digit 0 = units
- SCAN_DIV, 1000, clk cycles each digit stays selected (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- BinaryInput  input  WIDTH  two's-complement value to display
- Load  input  1  capture strobe; accepted only when Busy=0
- Busy  output  1  conversion in progress
- Done  output  1  one-cycle pulse when new result is committed
- SignOut  output  1  1 = displayed value negative
- Overflow  output  1  1 = magnitude exceeds 10^DIGITS−1
- Segments  output  7  {g,f,e,d,c,b,a}, 1 = segment lit
- DigitSelect  output  DIGITS  one-hot active digit, bit i = digit i

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: Load=1 → latch sign = BinaryInput[WIDTH−1], magnitude = |BinaryInput| as WIDTH-bit unsigned (−2^(WIDTH−1) gives 2^(WIDTH−1), no wrap), clear BCD accumulator and overflow flag, shift count = 0 → SHIFT.
- SHIFT: each cycle add 3 to every BCD nibble ≥5, then shift {BCD, magnitude} left 1. The bit shifted out of the top BCD nibble ORs into a sticky overflow flag. After WIDTH shifts → COMMIT.
- COMMIT: copy BCD, sign and overflow into display registers, assert Done → IDLE.
- Load while Busy=1 is ignored and never queued.
- Display registers hold the previous result until COMMIT.
- Overflow=1: every digit shows segment g only (7'b1000000); SignOut still reflects sign.
- Digit values 0–9 map to standard patterns.
- Scan: a counter runs 0..SCAN_DIV−1. At terminal count the digit index advances and wraps DIGITS−1→0. Segments and DigitSelect are registered together, so they never disagree for a cycle. Scanning runs independently of conversion.

## Timing
- Reset values: Busy=0, Done=0, SignOut=0, Overflow=0, display digits all 0, scan counter 0, digit index 0, DigitSelect=1, Segments=pattern of digit 0 with value 0 (7'b0111111, or blank under the macro).
- Load sampled at edge 0 → Busy=1 from edge 1 through edge WIDTH. Done=1 and the new display/SignOut/Overflow are visible after edge WIDTH+1. Busy=0 in that same cycle. Total latency WIDTH+1 cycles.
- Load is accepted again in the Done cycle (state is IDLE). Back-to-back conversions are every WIDTH+1 cycles.
- Reset mid-conversion aborts the conversion and restores all reset values, including the display registers.
- Segments/DigitSelect change one cycle after the scan terminal count or after a COMMIT that changes the selected digit's value.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero digit show 7'b0000000. Digit 0 is never blanked, so value 0 shows "0". Overflow dashes are not blanked.
- Undefined: all digits show their value, including leading zeros.

## Test plan
- WIDTH=8, DIGITS=3: Load 8'h7B → Busy 8 cycles, Done at cycle 9, digits 1,2,3, SignOut=0, Overflow=0.
- Load 8'h80 → digits 1,2,8, SignOut=1. Load 8'hFF → 0,0,1 (blank,blank,1 with LEADING_ZERO_BLANK_EN), SignOut=1.
- DIGITS=2: Load 8'h64 (100) → Overflow=1, both digits 7'b1000000. Load 8'h63 → 9,9, Overflow=0.
- Load 8'h05, then Load 8'h09 three cycles later (Busy=1) → second ignored, result 5, only one Done pulse. Reset asserted at cycle 4 of a conversion → all outputs at reset values, no Done.
- SCAN_DIV=4, DIGITS=3: DigitSelect 001→010→100→001, each held exactly 4 cycles. Segments match the digit selected in the same cycle.
